// File: rtl/sprite_compositor_pkg.sv
// Shared display constants and helpers for the sprite compositor.
// Optional collision logic is enabled by defining SPRITE_COLLISION_EN.
package sprite_compositor_pkg;

    localparam int H_DISPLAY       = 640;
    localparam int V_DISPLAY       = 480;
    localparam int DEF_COLOR_W     = 9;
    localparam int DEF_TRANSPARENT = 0;

    function automatic logic on_screen(input int unsigned h, input int unsigned v);
        return (h < H_DISPLAY) && (v < V_DISPLAY);
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// One sprite channel: S0 hit-test, horizontal mirror and registered ROM address.
// Built identically with or without SPRITE_COLLISION_EN.
module sprite_hit_unit
    import sprite_compositor_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 32,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] h,
    input  logic [COORD_W-1:0] v,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               en,
    input  logic               flip,
    input  logic               active,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);
    localparam int XB  = $clog2(SPR_W);
    localparam int CW1 = COORD_W + 1;

    logic [CW1-1:0]     h_e, v_e, x_e, y_e;
    logic               in_x, in_y, hit_d;
    logic [XB-1:0]      col_raw, col;
    logic [COORD_W-1:0] dy;
    logic [ADDR_W-1:0]  addr_d;

    // One extra bit so that x+SPR_W near the top of the range cannot wrap.
    assign h_e = {1'b0, h};
    assign v_e = {1'b0, v};
    assign x_e = {1'b0, x};
    assign y_e = {1'b0, y};

    assign in_x  = (h_e >= x_e) && (h_e < x_e + CW1'(SPR_W));
    assign in_y  = (v_e >= y_e) && (v_e < y_e + CW1'(SPR_H));
    assign hit_d = en && active && in_x && in_y;

    // SPR_W is a power of two, so SPR_W-1-col is simply the bitwise inverse.
    assign col_raw = h[XB-1:0] - x[XB-1:0];
    assign col     = flip ? ~col_raw : col_raw;
    assign dy      = v - y;
    assign addr_d  = hit_d ? ADDR_W'({dy, col}) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit  <= 1'b0;
            addr <= '0;
        end else begin
            hit  <= hit_d;
            addr <= addr_d;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage N-channel sprite mixer: hit-test/address, ROM fetch, priority overlay.
// Define SPRITE_COLLISION_EN to build the sticky per-frame collision flags.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int ADDR_W      = 10,
    parameter int TRANSPARENT = DEF_TRANSPARENT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             h_count,
    input  logic [COORD_W-1:0]             v_count,
    input  logic                           frame_start,
    input  logic [COLOR_W-1:0]             bg_color,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES-1:0]         spr_flip_h,
    output logic [NUM_SPRITES*ADDR_W-1:0]  spr_addr,
    input  logic [NUM_SPRITES*COLOR_W-1:0] spr_data,
    output logic [COLOR_W-1:0]             rgb_out,
    output logic                           rgb_valid,
    output logic [NUM_SPRITES-1:0]         collision
);
    // Free-running pipeline: one pixel accepted per clock, no valid/ready backpressure.
    logic                   active_s0, active_s1, active_s2;
    logic [COLOR_W-1:0]     bg_s1, bg_s2, rgb_d;
    logic [NUM_SPRITES-1:0] hit_s1, hit_s2, opaque;

    assign active_s0 = on_screen(32'(h_count), 32'(v_count));

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        sprite_hit_unit #(
            .COORD_W(COORD_W),
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .clk   (clk),
            .rst   (rst),
            .h     (h_count),
            .v     (v_count),
            .x     (spr_x[i*COORD_W +: COORD_W]),
            .y     (spr_y[i*COORD_W +: COORD_W]),
            .en    (spr_en[i]),
            .flip  (spr_flip_h[i]),
            .active(active_s0),
            .hit   (hit_s1[i]),
            .addr  (spr_addr[i*ADDR_W +: ADDR_W])
        );
    end

    // Lowest index wins, so scan from the highest index down and let later hits override.
    always_comb begin
        opaque = '0;
        rgb_d  = bg_s2;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            opaque[i] = hit_s2[i] && (spr_data[i*COLOR_W +: COLOR_W] != COLOR_W'(TRANSPARENT));
            if (opaque[i]) rgb_d = spr_data[i*COLOR_W +: COLOR_W];
        end
        if (!active_s2) rgb_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_s1 <= 1'b0;
            active_s2 <= 1'b0;
            bg_s1     <= '0;
            bg_s2     <= '0;
            hit_s2    <= '0;
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            active_s1 <= active_s0;
            active_s2 <= active_s1;
            bg_s1     <= bg_color;
            bg_s2     <= bg_s1;
            hit_s2    <= hit_s1;
            rgb_out   <= rgb_d;
            rgb_valid <= active_s2;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_set;

    always_comb begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (opaque[i]) cnt++;
        end
        coll_set = (active_s2 && cnt >= 2) ? opaque : '0;
    end

    // A set on the same cycle as frame_start survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              collision <= '0;
        else if (frame_start) collision <= coll_set;
        else                  collision <= collision | coll_set;
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign collision          = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a constant-per-sprite ROM model.
// Collision checks are built only when SPRITE_COLLISION_EN is defined.
module tb_sprite_compositor;
    localparam int N    = 8;
    localparam int CW   = 10;
    localparam int COLW = 9;
    localparam int AW   = 10;

    logic              clk, rst;
    logic [CW-1:0]     h_count, v_count;
    logic              frame_start;
    logic [COLW-1:0]   bg_color;
    logic [N*CW-1:0]   spr_x, spr_y;
    logic [N-1:0]      spr_en, spr_flip_h, collision;
    logic [N*AW-1:0]   spr_addr;
    logic [N*COLW-1:0] spr_data;
    logic [COLW-1:0]   rgb_out;
    logic              rgb_valid;
    logic [COLW-1:0]   rom_color [N];

    int n_checks = 0;
    int n_fails  = 0;

    sprite_compositor #(
        .NUM_SPRITES(N), .COORD_W(CW), .COLOR_W(COLW),
        .SPR_W(32), .SPR_H(32), .ADDR_W(AW), .TRANSPARENT(0)
    ) dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .frame_start(frame_start), .bg_color(bg_color),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_flip_h(spr_flip_h),
        .spr_addr(spr_addr), .spr_data(spr_data),
        .rgb_out(rgb_out), .rgb_valid(rgb_valid), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: each sprite returns one fixed texel colour one cycle after its address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) spr_data[i*COLW +: COLW] <= rom_color[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int h, input int v);
        @(negedge clk);
        h_count = CW'(h);
        v_count = CW'(v);
    endtask

    task automatic check_pix(input string tag, input int h, input int v,
                             input logic [COLW-1:0] exp_rgb, input logic exp_valid);
        drive(h, v);
        repeat (3) @(negedge clk);
        chk({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
        chk({tag, "_valid"}, 32'(rgb_valid), 32'(exp_valid));
    endtask

    task automatic check_addr(input string tag, input int h, input int v, input int idx, input int exp);
        drive(h, v);
        @(negedge clk);
        chk(tag, 32'(spr_addr[idx*AW +: AW]), 32'(exp));
    endtask

    task automatic place(input int idx, input int x, input int y, input logic en, input logic flip);
        spr_x[idx*CW +: CW] = CW'(x);
        spr_y[idx*CW +: CW] = CW'(y);
        spr_en[idx]         = en;
        spr_flip_h[idx]     = flip;
    endtask

    initial begin
        rst         = 1'b1;
        h_count     = '0;
        v_count     = '0;
        frame_start = 1'b0;
        bg_color    = 9'h0AA;
        spr_x       = '0;
        spr_y       = '0;
        spr_en      = '0;
        spr_flip_h  = '0;
        for (int i = 0; i < N; i++) rom_color[i] = '0;

        repeat (2) @(negedge clk);
        chk("reset_rgb", 32'(rgb_out), 32'h0);
        chk("reset_valid", 32'(rgb_valid), 32'h0);
        chk("reset_coll", 32'(collision), 32'h0);
        chk("reset_addr", 32'(spr_addr[AW-1:0]), 32'h0);
        rst = 1'b0;

        // Background only: active area, blanking, last active pixel, two-cycle lag
        check_pix("t1_active", 10, 10, 9'h0AA, 1'b1);
        check_pix("t1_hblank", 700, 10, 9'h000, 1'b0);
        check_pix("t1_vblank", 10, 500, 9'h000, 1'b0);
        check_pix("t1_lastpix", 639, 479, 9'h0AA, 1'b1);
        drive(10, 500);
        repeat (2) @(negedge clk);
        drive(20, 20);
        @(negedge clk);
        chk("t1_lag1_valid", 32'(rgb_valid), 32'h0);
        @(negedge clk);
        chk("t1_lag2_valid", 32'(rgb_valid), 32'h0);
        @(negedge clk);
        chk("t1_lag3_valid", 32'(rgb_valid), 32'h1);
        chk("t1_lag3_rgb", 32'(rgb_out), 32'h0AA);

        // Single sprite at (100,50)
        place(0, 100, 50, 1'b1, 1'b0);
        rom_color[0] = 9'h1C0;
        check_addr("t2_addr_origin", 100, 50, 0, 0);
        check_addr("t2_addr_mid", 110, 52, 0, 74);
        check_addr("t2_addr_corner", 131, 81, 0, 1023);
        check_pix("t2_tl", 100, 50, 9'h1C0, 1'b1);
        check_pix("t2_br", 131, 81, 9'h1C0, 1'b1);
        check_pix("t2_right", 132, 50, 9'h0AA, 1'b1);
        check_pix("t2_below", 100, 82, 9'h0AA, 1'b1);
        check_pix("t2_left", 99, 50, 9'h0AA, 1'b1);

        // Horizontal mirror
        place(0, 100, 50, 1'b1, 1'b1);
        check_addr("t3_flip_left", 100, 50, 0, 31);
        check_addr("t3_flip_right", 131, 50, 0, 0);
        check_addr("t3_flip_mid", 110, 52, 0, 85);

        // Disabled sprite
        place(0, 100, 50, 1'b0, 1'b0);
        check_pix("dis_pix", 110, 60, 9'h0AA, 1'b1);
        check_addr("dis_addr", 110, 60, 0, 0);

        // Priority between overlapping sprites 0 and 3
        place(0, 200, 100, 1'b1, 1'b0);
        place(3, 210, 100, 1'b1, 1'b0);
        rom_color[3] = 9'h038;
        check_pix("t4_both", 215, 105, 9'h1C0, 1'b1);
        check_pix("t4_spr0only", 205, 105, 9'h1C0, 1'b1);
        check_pix("t4_spr3only", 235, 105, 9'h038, 1'b1);
        rom_color[0] = 9'h000;
        check_pix("t4_transp", 215, 105, 9'h038, 1'b1);
        rom_color[0] = 9'h1C0;
`ifndef SPRITE_COLLISION_EN
        check_pix("t4_overlap_again", 215, 105, 9'h1C0, 1'b1);
        chk("coll_disabled", 32'(collision), 32'h0);
`endif

        // Right-edge clipping and no wrap
        place(0, 200, 100, 1'b0, 1'b0);
        place(3, 210, 100, 1'b0, 1'b0);
        place(1, 630, 60, 1'b1, 1'b0);
        rom_color[1] = 9'h007;
        check_pix("t5_first", 630, 70, 9'h007, 1'b1);
        check_pix("t5_last", 639, 70, 9'h007, 1'b1);
        check_pix("t5_before", 629, 70, 9'h0AA, 1'b1);
        check_pix("t5_blank", 640, 70, 9'h000, 1'b0);
        check_addr("t5_nohit_addr", 640, 70, 1, 0);
        check_pix("t5_nowrap", 0, 70, 9'h0AA, 1'b1);
        place(1, 1010, 60, 1'b1, 1'b0);
        check_pix("t5_nowrap_hi", 5, 70, 9'h0AA, 1'b1);
        place(1, 0, 0, 1'b0, 1'b0);

`ifdef SPRITE_COLLISION_EN
        // Sticky collision flags between sprites 0 and 2
        drive(10, 10);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_cleared", 32'(collision), 32'h0);
        place(0, 200, 100, 1'b1, 1'b0);
        place(2, 210, 100, 1'b1, 1'b0);
        rom_color[2] = 9'h049;
        check_pix("t6_overlap", 215, 105, 9'h1C0, 1'b1);
        chk("t6_set", 32'(collision), 32'h05);
        check_pix("t6_apart", 205, 105, 9'h1C0, 1'b1);
        chk("t6_held", 32'(collision), 32'h05);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        chk("t6_frame_clear", 32'(collision), 32'h0);
        drive(215, 105);
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        chk("t6_set_wins", 32'(collision), 32'h05);
`endif

        // Asynchronous reset mid-line, then black until two edges after release
        place(0, 0, 0, 1'b0, 1'b0);
        place(2, 0, 0, 1'b0, 1'b0);
        check_pix("rst_pre", 50, 20, 9'h0AA, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rgb", 32'(rgb_out), 32'h0);
        chk("rst_async_valid", 32'(rgb_valid), 32'h0);
        chk("rst_async_coll", 32'(collision), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_black1", 32'(rgb_out), 32'h0);
        @(negedge clk);
        chk("rst_black2", 32'(rgb_out), 32'h0);
        chk("rst_black2_valid", 32'(rgb_valid), 32'h0);
        @(negedge clk);
        chk("rst_resume", 32'(rgb_out), 32'h0AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
